// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM encoding and command-byte layout for the
// SPI register peripheral.
package spi_reg_pkg;

    localparam int ADDR_W     = 7;
    localparam int CMD_RD_BIT = 7;
    localparam int CMD_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

endpackage

// File: rtl/spi_pad_sync.sv
// spi_pad_sync: 2-FF synchronisers for the SPI pads plus SCK/CSN
// edge detection, all in the sys_clk domain.
module spi_pad_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic csn_pad,
    input  logic sck_pad,
    input  logic mosi_pad,
    output logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic csn_fall,
    output logic csn_rise
);

    logic csn_meta_q, csn_sync_q, csn_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic csn_meta_d, csn_sync_d, csn_prev_d;
    logic sck_meta_d, sck_sync_d, sck_prev_d;
    logic mosi_meta_d, mosi_sync_d;

    // Next value of every synchroniser stage and edge-history flop.
    always_comb begin
        csn_meta_d  = csn_pad;
        csn_sync_d  = csn_meta_q;
        csn_prev_d  = csn_sync_q;
        sck_meta_d  = sck_pad;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        mosi_meta_d = mosi_pad;
        mosi_sync_d = mosi_meta_q;
    end

    // Reset parks the chip select deasserted and SCK low so no false
    // edge appears when reset is released with the pads idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            csn_meta_q  <= csn_meta_d;
            csn_sync_q  <= csn_sync_d;
            csn_prev_q  <= csn_prev_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign mosi     = mosi_sync_q;
    assign sck_rise =  sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q &  sck_prev_q;
    assign csn_fall = ~csn_sync_q &  csn_prev_q;
    assign csn_rise =  csn_sync_q & ~csn_prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: SPI mode-0 slave exposing config and status
// registers. Define SPI_ADDR_AUTOINC_EN for address auto-increment.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int BYTE_W = 8,
    parameter int N_RW   = 4,
    parameter int N_RO   = 4,
    parameter logic [N_RW*BYTE_W-1:0] RW_RESET = '0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     CSN_PAD,
    input  logic                     SCK_PAD,
    input  logic                     MOSI_PAD,
    output logic                     MISO_PAD,
    output logic [N_RW*BYTE_W-1:0]   rw_regs,
    input  logic [N_RO*BYTE_W-1:0]   ro_regs,
    output logic                     wr_stb,
    output logic                     rd_stb,
    output logic [ADDR_W-1:0]        stb_addr
);

    localparam int SR_W  = (BYTE_W > CMD_W) ? BYTE_W : CMD_W;
    localparam int N_ALL = N_RW + N_RO;
    localparam logic [7:0] LAST_CMD  = 8'(CMD_W - 1);
    localparam logic [7:0] LAST_DATA = 8'(BYTE_W - 1);

    logic mosi_s, sck_rise, sck_fall, csn_fall, csn_rise;

    spi_pad_sync u_sync (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .csn_pad  (CSN_PAD),
        .sck_pad  (SCK_PAD),
        .mosi_pad (MOSI_PAD),
        .mosi     (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csn_fall (csn_fall),
        .csn_rise (csn_rise)
    );

    state_e                  state_q, state_d;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    logic [SR_W-2:0]         sh_q, sh_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [BYTE_W-1:0]       miso_q, miso_d;
    logic [N_RW*BYTE_W-1:0]  rw_q, rw_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    wr_stb_q, wr_stb_d;
    logic                    rd_stb_q, rd_stb_d;
    logic [ADDR_W-1:0]       stb_addr_q, stb_addr_d;
    logic [SR_W-1:0]         byte_in;
    logic [ADDR_W-1:0]       nxt_addr;

    function automatic logic [BYTE_W-1:0] read_byte(input logic [ADDR_W-1:0] a);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_RW; k++)
            if (int'(a) == k) r = rw_q[k*BYTE_W +: BYTE_W];
        for (int k = 0; k < N_RO; k++)
            if (int'(a) == N_RW + k) r = ro_regs[k*BYTE_W +: BYTE_W];
        return r;
    endfunction

    function automatic logic is_status(input logic [ADDR_W-1:0] a);
        return (int'(a) >= N_RW) && (int'(a) < N_ALL);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_ADDR_AUTOINC_EN
        return (int'(a) == N_ALL - 1) ? '0 : a + 1'b1;
`else
        return a;
`endif
    endfunction

    assign byte_in = {sh_q, mosi_s};

    // Frame decoder: command byte, then write or read data bytes.
    // The status pop is deferred to the first SCK rise of the byte so
    // that a prefetched byte the host never clocks out is not popped.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        rw_d       = rw_q;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        stb_addr_d = stb_addr_q;
        nxt_addr   = '0;
        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                miso_d    = '0;
                rd_pend_d = 1'b0;
                if (csn_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (sck_rise) begin
                    sh_d      = byte_in[SR_W-2:0];
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == LAST_CMD) begin
                        bit_cnt_d = '0;
                        addr_d    = byte_in[ADDR_W-1:0];
                        if (byte_in[CMD_RD_BIT]) begin
                            state_d   = ST_RDATA;
                            miso_d    = read_byte(byte_in[ADDR_W-1:0]);
                            rd_pend_d = is_status(byte_in[ADDR_W-1:0]);
                            rd_addr_d = byte_in[ADDR_W-1:0];
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (sck_rise) begin
                    sh_d      = byte_in[SR_W-2:0];
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        for (int k = 0; k < N_RW; k++)
                            if (int'(addr_q) == k)
                                rw_d[k*BYTE_W +: BYTE_W] = byte_in[BYTE_W-1:0];
                        if (int'(addr_q) < N_RW) begin
                            wr_stb_d   = 1'b1;
                            stb_addr_d = addr_q;
                        end
                        addr_d = next_addr(addr_q);
                    end
                end
            end
            ST_RDATA: begin
                if (sck_rise) begin
                    if (rd_pend_q && bit_cnt_q == '0) begin
                        rd_stb_d   = 1'b1;
                        stb_addr_d = rd_addr_q;
                        rd_pend_d  = 1'b0;
                    end
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        nxt_addr  = next_addr(addr_q);
                        addr_d    = nxt_addr;
                        miso_d    = read_byte(nxt_addr);
                        rd_pend_d = is_status(nxt_addr);
                        rd_addr_d = nxt_addr;
                    end
                end else if (sck_fall && bit_cnt_q != '0) begin
                    miso_d = {miso_q[BYTE_W-2:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (csn_rise) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            miso_d     = '0;
            rd_pend_d  = 1'b0;
            rw_d       = rw_q;
            wr_stb_d   = 1'b0;
            rd_stb_d   = 1'b0;
            stb_addr_d = stb_addr_q;
        end
    end

    // State, shift and register-file flops.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            miso_q     <= '0;
            rw_q       <= RW_RESET;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            stb_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            rw_q       <= rw_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            stb_addr_q <= stb_addr_d;
        end
    end

    assign MISO_PAD = miso_q[BYTE_W-1];
    assign rw_regs  = rw_q;
    assign wr_stb   = wr_stb_q;
    assign rd_stb   = rd_stb_q;
    assign stb_addr = stb_addr_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: directed SPI frames against hand-computed
// register images, strobe counts and read-back bytes.
module tb_spi_reg_peripheral;

    localparam logic [31:0] RST_IMG = 32'hD4C3B2A1;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        CSN_PAD   = 1'b1;
    logic        SCK_PAD   = 1'b0;
    logic        MOSI_PAD  = 1'b0;
    logic        MISO_PAD;
    logic [31:0] rw_regs;
    logic [31:0] ro_regs   = 32'h9C8B7A43;
    logic        wr_stb;
    logic        rd_stb;
    logic [6:0]  stb_addr;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [6:0]  last_wr_addr = '0;
    logic [6:0]  last_rd_addr = '0;
    logic [31:0] exp_rw;

    spi_reg_peripheral #(
        .BYTE_W   (8),
        .N_RW     (4),
        .N_RO     (4),
        .RW_RESET (RST_IMG)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .CSN_PAD   (CSN_PAD),
        .SCK_PAD   (SCK_PAD),
        .MOSI_PAD  (MOSI_PAD),
        .MISO_PAD  (MISO_PAD),
        .rw_regs   (rw_regs),
        .ro_regs   (ro_regs),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .stb_addr  (stb_addr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (wr_stb) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= stb_addr;
        end
        if (rd_stb) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= stb_addr;
        end
    end

    task automatic spi_start();
        CSN_PAD = 1'b0;
        #100;
    endtask

    task automatic spi_stop();
        #50;
        CSN_PAD = 1'b1;
        #150;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI_PAD = tx[i];
            #50;
            rx[i]   = MISO_PAD;
            SCK_PAD = 1'b1;
            #50;
            SCK_PAD = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (5) @(posedge sys_clk);
        #1;
        checks++;
        if (rw_regs !== RST_IMG) begin
            errors++;
            $display("FAIL reset_rw: got %h want %h", rw_regs, RST_IMG);
        end
        checks++;
        if (MISO_PAD !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b want 0", MISO_PAD);
        end
        checks++;
        if ({wr_stb, rd_stb} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stb: got %b want 00", {wr_stb, rd_stb});
        end
        checks++;
        if (stb_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00", stb_addr);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #200;
        exp_rw = RST_IMG;
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int w0 = wr_cnt;
        spi_start();
        spi_bits(8'h01, 8, rx);
        spi_bits(8'hA5, 8, rx);
        spi_stop();
        exp_rw[15:8] = 8'hA5;
        checks++;
        if (rw_regs !== exp_rw) begin
            errors++;
            $display("FAIL write_rw: got %h want %h", rw_regs, exp_rw);
        end
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL write_stb_cnt: got %0d want 1", wr_cnt - w0);
        end
        checks++;
        if (last_wr_addr !== 7'd1) begin
            errors++;
            $display("FAIL write_stb_addr: got %h want 01", last_wr_addr);
        end
    endtask

    task automatic test_read_status();
        logic [7:0] rx;
        int r0 = rd_cnt;
        spi_start();
        spi_bits(8'h84, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        checks++;
        if (rx !== 8'h43) begin
            errors++;
            $display("FAIL rd_status_data: got %h want 43", rx);
        end
        checks++;
        if (rd_cnt - r0 != 1) begin
            errors++;
            $display("FAIL rd_status_stb_cnt: got %0d want 1", rd_cnt - r0);
        end
        checks++;
        if (last_rd_addr !== 7'd4) begin
            errors++;
            $display("FAIL rd_status_addr: got %h want 04", last_rd_addr);
        end
        checks++;
        if (MISO_PAD !== 1'b0) begin
            errors++;
            $display("FAIL miso_idle: got %b want 0", MISO_PAD);
        end
    endtask

    task automatic test_read_config();
        logic [7:0] rx;
        int r0 = rd_cnt;
        spi_start();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("FAIL rd_cfg_data: got %h want a5", rx);
        end
        checks++;
        if (rd_cnt != r0) begin
            errors++;
            $display("FAIL rd_cfg_stb: got %0d want 0", rd_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx;
        int w0 = wr_cnt;
        spi_start();
`ifdef SPI_ADDR_AUTOINC_EN
        spi_bits(8'h07, 8, rx);
`else
        spi_bits(8'h02, 8, rx);
`endif
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_stop();
`ifdef SPI_ADDR_AUTOINC_EN
        exp_rw[7:0] = 8'h22;
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL b2b_stb_cnt: got %0d want 1", wr_cnt - w0);
        end
        checks++;
        if (last_wr_addr !== 7'd0) begin
            errors++;
            $display("FAIL b2b_stb_addr: got %h want 00", last_wr_addr);
        end
`else
        exp_rw[23:16] = 8'h22;
        checks++;
        if (wr_cnt - w0 != 2) begin
            errors++;
            $display("FAIL b2b_stb_cnt: got %0d want 2", wr_cnt - w0);
        end
        checks++;
        if (last_wr_addr !== 7'd2) begin
            errors++;
            $display("FAIL b2b_stb_addr: got %h want 02", last_wr_addr);
        end
`endif
        checks++;
        if (rw_regs !== exp_rw) begin
            errors++;
            $display("FAIL b2b_rw: got %h want %h", rw_regs, exp_rw);
        end
    endtask

    task automatic test_unmapped_write();
        logic [7:0] rx;
        int w0 = wr_cnt;
        spi_start();
        spi_bits(8'h05, 8, rx);
        spi_bits(8'hFF, 8, rx);
        spi_stop();
        checks++;
        if (rw_regs !== exp_rw) begin
            errors++;
            $display("FAIL ro_write_rw: got %h want %h", rw_regs, exp_rw);
        end
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL ro_write_stb: got %0d want 0", wr_cnt - w0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int w0 = wr_cnt;
        spi_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hFF, 5, rx);
        spi_stop();
        checks++;
        if (rw_regs !== exp_rw || wr_cnt != w0) begin
            errors++;
            $display("FAIL abort_rw: got %h/%0d want %h/0",
                     rw_regs, wr_cnt - w0, exp_rw);
        end
        spi_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h3C, 8, rx);
        spi_stop();
        exp_rw[31:24] = 8'h3C;
        checks++;
        if (rw_regs !== exp_rw) begin
            errors++;
            $display("FAIL abort_next_rw: got %h want %h", rw_regs, exp_rw);
        end
        checks++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 7'd3) begin
            errors++;
            $display("FAIL abort_next_stb: got %0d@%h want 1@03",
                     wr_cnt - w0, last_wr_addr);
        end
    endtask

    task automatic test_unmapped_read();
        logic [7:0] rx;
        int r0 = rd_cnt;
        spi_start();
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        checks++;
        if (rx !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_rd_data: got %h want 00", rx);
        end
        checks++;
        if (rd_cnt != r0) begin
            errors++;
            $display("FAIL unmapped_rd_stb: got %0d want 0", rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rx;
        spi_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h5A, 8, rx);
        spi_stop();
        checks++;
        if (rw_regs[23:16] !== 8'h5A) begin
            errors++;
            $display("FAIL mid_pre_reg2: got %h want 5a", rw_regs[23:16]);
        end
        spi_start();
        spi_bits(8'h81, 8, rx);
        #50;
        checks++;
        if (MISO_PAD !== 1'b1) begin
            errors++;
            $display("FAIL mid_msb_ready: got %b want 1", MISO_PAD);
        end
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (rw_regs !== RST_IMG) begin
            errors++;
            $display("FAIL mid_reset_rw: got %h want %h", rw_regs, RST_IMG);
        end
        checks++;
        if (MISO_PAD !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_miso: got %b want 0", MISO_PAD);
        end
        CSN_PAD = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #200;
        spi_start();
        spi_bits(8'h82, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        checks++;
        if (rx !== 8'hC3) begin
            errors++;
            $display("FAIL mid_after_rd: got %h want c3", rx);
        end
    endtask

    initial begin
        exp_rw = RST_IMG;
        test_reset();
        test_write();
        test_read_status();
        test_read_config();
        test_back_to_back();
        test_unmapped_write();
        test_abort();
        test_unmapped_read();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, register and SPI word width.
REQ-002 SHALL have parameter N_RW, default 4, count of host-writable config registers (1..64).
REQ-003 SHALL have parameter N_RO, default 4, count of read-only status registers (1..64); N_RW+N_RO <= 128.
REQ-004 SHALL have parameter RW_RESET, default 0, N_RW*BYTE_W reset image of the config registers.
REQ-005 SHALL have the port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have the port sys_rst_n, input, 1 bit: synchronous reset, active-low.
REQ-007 SHALL have the port CSN_PAD, input, 1 bit: SPI chip select, active-low, asynchronous to sys_clk.
REQ-008 SHALL have the port SCK_PAD, input, 1 bit: SPI clock, mode 0, asynchronous.
REQ-009 SHALL have the port MOSI_PAD, input, 1 bit: SPI data in, MSB first.
REQ-010 SHALL have the port MISO_PAD, output, 1 bit: SPI data out, MSB first.
REQ-011 SHALL have the port rw_regs, output, N_RW*BYTE_W bits: config registers; register k occupies bits [k*BYTE_W +: BYTE_W].
REQ-012 SHALL have the port ro_regs, input, N_RO*BYTE_W bits: status registers, with the same packing.
REQ-013 SHALL have the port wr_stb, output, 1 bit: one-cycle pulse when a config register is written.
REQ-014 SHALL have the port rd_stb, output, 1 bit: one-cycle pulse when a status register byte is captured for shifting (FIFO-pop hook).
REQ-015 SHALL have the port stb_addr, output, 7 bits: register address qualified by wr_stb or rd_stb.

Function
REQ-016 SHALL pass CSN_PAD, SCK_PAD and MOSI_PAD through 2-FF synchronisers, then detect SCK rise and fall and CSN fall and rise from the synchronised values.
REQ-017 SHALL operate correctly for SCK frequency <= sys_clk/8.
REQ-018 SHALL use the address map: 0..N_RW-1 = config registers; N_RW..N_RW+N_RO-1 = status registers; all other addresses unmapped.
REQ-019 SHALL interpret the first byte of a frame as the command byte: bit7 = 1 read, 0 write; bits[6:0] = start address.
REQ-020 SHALL implement the FSM states IDLE, CMD, WDATA and RDATA.
REQ-021 SHALL move IDLE->CMD on CSN fall.
REQ-022 SHALL move CMD->WDATA or CMD->RDATA after the 8th sampled SCK rise.
REQ-023 SHALL move any state->IDLE on CSN rise.
REQ-024 SHALL sample MOSI on SCK rise and shift MISO on SCK fall.
REQ-025 SHALL, in WDATA, on each completed byte write it to a config address and pulse wr_stb for one cycle with stb_addr = that address in the cycle after the 8th rise.
REQ-026 SHALL ignore writes to status or unmapped addresses: no register change and no wr_stb.
REQ-027 SHALL, in RDATA, load the shift register at the 8th rise of the previous byte, so that its MSB is on MISO before the next first SCK rise.
REQ-028 SHALL return 0x00 for unmapped reads.
REQ-029 SHALL pulse rd_stb only for status addresses.
REQ-030 SHALL, on CSN rise mid-byte, discard the partial byte: no write and no strobe.
REQ-031 SHALL hold MISO_PAD at 0 while CSN is high.
REQ-032 SHALL give any read-after-write in a later frame the written value.
REQ-033 SHALL give rw_regs 0 cycles of latency from the internal register update.

Reset
REQ-034 SHALL, while sys_rst_n = 0 at a sys_clk rising edge, set: FSM to IDLE, bit counter = 0, rw_regs = RW_RESET, wr_stb = 0, rd_stb = 0, stb_addr = 0, MISO_PAD = 0, synchronisers to CSN = 1 and SCK = 0.
REQ-035 SHALL abort any frame in progress when reset is asserted; after release, SHALL ignore traffic until the next CSN fall.

Configuration
REQ-036 SHALL, with SPI_ADDR_AUTOINC_EN defined, increment the address after each data byte, wrapping from N_RW+N_RO-1 to 0.
REQ-037 SHALL, without SPI_ADDR_AUTOINC_EN, keep the address fixed for the whole frame, so that repeated bytes access the same register (FIFO streaming).

Structure
REQ-038 SHALL place the FSM state encoding, CMD_RD_BIT = 7 and ADDR_W = 7 in shared package spi_reg_pkg.
REQ-039 SHALL use one sub-module, spi_pad_sync, containing the synchronisers and edge detectors; all remaining logic SHALL be in spi_reg_peripheral.

Verification
REQ-040 SHALL be verified by: write frame 0x01,0xA5 -> rw_regs reg1 = 0xA5, one wr_stb with stb_addr = 1, other registers unchanged.
REQ-041 SHALL be verified by: ro_regs reg0 = 0x43, frame 0x84 (N_RW = 4) then one dummy byte -> MISO returns 0x43 and one rd_stb with stb_addr = 4.
REQ-042 SHALL be verified by: with autoinc, frame 0x07,0x11,0x22 on default parameters -> write to 7 ignored, then address wraps to 0 and reg0 = 0x22.
REQ-043 SHALL be verified by: CSN rise after 5 bits of a data byte -> no wr_stb, register unchanged, and the next frame decodes normally.
REQ-044 SHALL be verified by: read of address 0x7F -> 0x00 and no rd_stb.
REQ-045 SHALL be verified by: sys_rst_n low mid-frame after reg2 was written with 0x5A -> reg2 returns to RW_RESET and MISO = 0.
